// File: rtl/bcd_disp_scan_pkg.sv
// -----------------------------------------------------------------------------
// bcd_disp_scan_pkg
// Shared constants for the six-digit multiplexed seven-segment display scanner:
// the digit count, the active-low segment patterns and the packed value
// type that flows through the shadow/active registers.
// Segment bit order is {dp,g,f,e,d,c,b,a}. A 0 bit lights the segment.
// -----------------------------------------------------------------------------
package bcd_disp_scan_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;  // segment g only
  localparam logic [7:0] SEG_BLANK = 8'hFF;  // everything dark

  // One displayable value: overflow flag plus six packed BCD digits.
  typedef struct packed {
    logic        ovf;
    logic [23:0] data;
  } disp_val_t;

endpackage

// File: rtl/bcd_disp_scan_bcd_to_seg.sv
// -----------------------------------------------------------------------------
// bcd_to_seg
// Purely combinational BCD to active-low seven-segment decoder.
// Codes 10-15 are not BCD and are shown as a dash.
// Ports:
//   bcd [3:0] in  - digit value
//   seg [7:0] out - active-low {dp,g,f,e,d,c,b,a}, dp always off
// -----------------------------------------------------------------------------
module bcd_to_seg
  import bcd_disp_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here via the
    // default arm); a missing assignment silently infers a latch.
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_disp_scan.sv
// -----------------------------------------------------------------------------
// bcd_disp_scan
// Time-multiplexed driver for a six-digit common-anode seven-segment display.
// A prescaler divides clk down to one digit slot per SCAN_DIV clocks; the
// digit index walks 0..5 and its 5->0 wrap marks a frame boundary. Incoming
// values are parked in a shadow register and only promoted to the displayed
// (active) register at a frame boundary, so a frame never mixes two values.
//
// Parameters:
//   SCAN_DIV - clocks per digit slot (2 .. 2**20)
// Ports:
//   clk          in  - system clock, rising edge
//   Rst_n        in  - asynchronous active-low reset
//   data [23:0]  in  - six packed BCD digits, [3:0] least significant
//   ovf          in  - overflow flag travelling with data
//   load         in  - single-cycle strobe qualifying data/ovf
//   seg [7:0]    out - active-low segments {dp,g,f,e,d,c,b,a}, registered
//   dig_sel [5:0] out - active-low one-hot digit enable, registered
//   frame        out - one-cycle pulse in the cycle the index wraps to 0
// Build option:
//   LZB_EN - when defined, leading zeros above the most significant nonzero
//            digit are blanked (digit 0 never; not while ovf is shown).
// -----------------------------------------------------------------------------
module bcd_disp_scan
  import bcd_disp_scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        Rst_n,
  input  logic [23:0] data,
  input  logic        ovf,
  input  logic        load,
  output logic [7:0]  seg,
  output logic [5:0]  dig_sel,
  output logic        frame
);

  localparam int              PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0]      IDX_LAST   = 3'(NUM_DIGITS - 1);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  disp_val_t     shadow_q;
  disp_val_t     active_q;
  disp_val_t     load_val;

  logic          slot_end;   // prescaler at terminal count
  logic          wrap;       // index about to go 5 -> 0
  logic [3:0]    cur_bcd;
  logic [7:0]    dec_seg;
  logic          blank_digit;
  logic [7:0]    seg_next;
  logic [5:0]    dig_next;

  assign load_val = '{ovf: ovf, data: data};
  assign slot_end = (presc == PRESC_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);

  // Select the nibble for the digit currently being scanned.
  always_comb begin
    cur_bcd = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) cur_bcd = active_q.data[4*i +: 4];
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

`ifdef LZB_EN
  logic [2:0] msd;  // highest nonzero digit position, 0 if all zero

  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (active_q.data[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    blank_digit = !active_q.ovf && (idx > msd);
  end
`else
  assign blank_digit = 1'b0;
`endif

  always_comb begin
    seg_next = dec_seg;
    if (active_q.ovf)     seg_next = SEG_DASH;
    else if (blank_digit) seg_next = SEG_BLANK;
    dig_next = ~(6'b000001 << idx);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      presc    <= '0;
      idx      <= 3'd0;
      frame    <= 1'b0;
      // NOTE: the value registers are reset explicitly so a load that was
      // pending when reset hit can never surface after release.
      shadow_q <= '0;
      active_q <= '0;
      seg      <= SEG_BLANK;
      dig_sel  <= 6'h3F;
    end else begin
      presc <= slot_end ? '0 : presc + PW'(1);
      if (slot_end) idx <= wrap ? 3'd0 : idx + 3'd1;
      frame <= wrap;

      if (load) shadow_q <= load_val;
      // A load landing on the boundary goes straight to the display; the
      // shadow copy taken the same cycle is then simply redundant.
      if (wrap) active_q <= load ? load_val : shadow_q;

      seg     <= seg_next;
      dig_sel <= dig_next;
    end
  end

endmodule

// File: tb/tb_bcd_disp_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_disp_scan
// Directed bench for bcd_disp_scan with SCAN_DIV=4 (4 clocks per digit,
// 24 clocks per frame). Cycle numbers count rising edges since reset release;
// outputs are sampled 1 time unit after each edge. Digit d of a frame whose
// pulse is seen at cycle F is on the outputs from F+1+4d to F+4+4d.
// Honours LZB_EN for the expected leading-zero pattern.
// -----------------------------------------------------------------------------
module tb_bcd_disp_scan;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic [23:0] data;
  logic        ovf;
  logic        load;
  logic [7:0]  seg;
  logic [5:0]  dig_sel;
  logic        frame;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int frame_cyc = 0;
  int base      = 0;

`ifdef LZB_EN
  localparam logic [7:0] LZ = 8'hFF;  // leading zero is blanked
`else
  localparam logic [7:0] LZ = 8'hC0;  // leading zero shown as 0
`endif

  bcd_disp_scan #(.SCAN_DIV(4)) dut (
    .clk     (clk),
    .Rst_n   (Rst_n),
    .data    (data),
    .ovf     (ovf),
    .load    (load),
    .seg     (seg),
    .dig_sel (dig_sel),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic goto(input int t);
    if (t > cyc) step(t - cyc);
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    step(1);
    while (frame !== 1'b1 && k < 60) begin
      step(1);
      k++;
    end
    checks++;
    assert (frame === 1'b1) else begin
      errors++;
      $error("FAIL frame_timeout observed=%b expected=1", frame);
    end
    frame_cyc = cyc;
  endtask

  task automatic load_word(input logic [23:0] d, input logic o);
    data = d;
    ovf  = o;
    load = 1'b1;
    step(1);
    load = 1'b0;
    data = '0;
    ovf  = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0;
    data  = '0;
    ovf   = 1'b0;
    load  = 1'b0;

    // Reset state, clock running.
    #12;
    check("rst_seg", seg, 8'hFF);
    check("rst_dig", 8'(dig_sel), 8'h3F);
    check("rst_frame", 8'(frame), 8'h00);

    // Reset release and scan timing.
    @(negedge clk);
    Rst_n = 1'b1;
    cyc   = 0;
    step(1);
    check("rel_dig0", 8'(dig_sel), 8'h3E);
    check("rel_seg0", seg, 8'hC0);
    check("rel_frame", 8'(frame), 8'h00);
    goto(4);
    check("slot0_end_dig", 8'(dig_sel), 8'h3E);
    goto(5);
    check("slot1_dig", 8'(dig_sel), 8'h3D);
    check("slot1_seg", seg, LZ);
    goto(23);
    check("pre_frame", 8'(frame), 8'h00);
    goto(24);
    check("frame1", 8'(frame), 8'h01);
    goto(25);
    check("frame1_len", 8'(frame), 8'h00);
    check("frame1_dig0", 8'(dig_sel), 8'h3E);
    goto(48);
    check("frame2", 8'(frame), 8'h01);
    frame_cyc = 48;

    // Mid-frame load is held back until the next frame.
    goto(58);
    load_word(24'h123456, 1'b0);
    goto(70);
    check("old_d5_dig", 8'(dig_sel), 8'h1F);
    check("old_d5_seg", seg, LZ);
    base = frame_cyc;
    wait_frame();
    check("frame_period", 8'(frame_cyc - base), 8'd24);
    goto(frame_cyc + 1);
    check("new_d0_seg", seg, 8'h82);
    check("new_d0_dig", 8'(dig_sel), 8'h3E);
    goto(frame_cyc + 9);
    check("new_d2_seg", seg, 8'h99);
    goto(frame_cyc + 21);
    check("new_d5_seg", seg, 8'hF9);
    check("new_d5_dig", 8'(dig_sel), 8'h1F);

    // Load coinciding with the wrap edge goes straight to the display.
    goto(frame_cyc + 23);
    data = 24'h000009;
    load = 1'b1;
    step(1);
    load = 1'b0;
    data = '0;
    check("bypass_frame", 8'(frame), 8'h01);
    base = cyc;
    goto(base + 1);
    check("bypass_d0", seg, 8'h90);
    goto(base + 5);
    check("bypass_d1", seg, LZ);
    goto(base + 21);
    check("bypass_d5", seg, LZ);
    frame_cyc = base;

    // Overflow shows dashes on every digit for the whole frame.
    goto(frame_cyc + 10);
    load_word(24'h999999, 1'b1);
    wait_frame();
    for (int d = 0; d < 6; d++) begin
      goto(frame_cyc + 1 + 4*d);
      check($sformatf("ovf_d%0d_first", d), seg, 8'hBF);
      goto(frame_cyc + 4 + 4*d);
      check($sformatf("ovf_d%0d_last", d), seg, 8'hBF);
    end

    // Non-BCD nibble shows a dash.
    goto(frame_cyc + 6);
    load_word(24'h00000A, 1'b0);
    wait_frame();
    goto(frame_cyc + 1);
    check("hex_a_d0", seg, 8'hBF);
    goto(frame_cyc + 5);
    check("hex_a_d1", seg, LZ);

    // Reset mid-frame with a pending load discards it.
    goto(frame_cyc + 8);
    load_word(24'h777777, 1'b0);
    step(2);
    #3;
    Rst_n = 1'b0;
    #1;
    check("midrst_seg", seg, 8'hFF);
    check("midrst_dig", 8'(dig_sel), 8'h3F);
    check("midrst_frame", 8'(frame), 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    Rst_n = 1'b1;
    cyc   = 0;
    step(1);
    check("rerel_dig0", 8'(dig_sel), 8'h3E);
    check("rerel_seg0", seg, 8'hC0);
    wait_frame();
    check("rerel_frame_cyc", 8'(frame_cyc), 8'd24);
    goto(frame_cyc + 1);
    check("rerel_d0", seg, 8'hC0);
    goto(frame_cyc + 5);
    check("rerel_d1", seg, LZ);
    goto(frame_cyc + 21);
    check("rerel_d5", seg, LZ);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_disp_scan.md
BCD_DISP_SCAN -- requirements
Module: bcd_disp_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clocks per digit slot (legal range 2..2^20).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state is updated on its rising edge.
REQ-003 SHALL have port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port data, input, 24 bits: six packed BCD digits; [3:0] is the least significant digit, [23:20] the most significant.
REQ-005 SHALL have port ovf, input, 1 bit: counter-overflow flag accompanying data.
REQ-006 SHALL have port load, input, 1 bit: single-cycle strobe; data and ovf are valid when load is high.
REQ-007 SHALL have port seg, output, 8 bits: active-low segments {dp,g,f,e,d,c,b,a}.
REQ-008 SHALL have port dig_sel, output, 6 bits: active-low, one-hot digit enable; bit i drives digit i.
REQ-009 SHALL have port frame, output, 1 bit: one-cycle pulse when a new frame begins.

Function
REQ-010 SHALL hold a shadow register {ovf,data}, written on every cycle in which load=1; the last load before a frame boundary wins.
REQ-011 SHALL hold an active register that is copied from shadow only at a frame boundary, so no frame ever mixes old and new digits.
REQ-012 SHALL copy load's data and ovf straight into active when load=1 coincides with a frame boundary, bypassing shadow.
REQ-013 SHALL run a prescaler 0..SCAN_DIV-1; at terminal count the prescaler returns to 0 and the digit index advances.
REQ-014 SHALL step the digit index 0,1,...,5 and then wrap to 0; the 5->0 wrap is the frame boundary.
REQ-015 SHALL assert frame for exactly the cycle in which the index wraps to 0.
REQ-016 SHALL register seg and dig_sel, giving one cycle of latency from the current index and active value.
REQ-017 SHALL decode digit values 0-9 to standard seven-segment patterns with dp off, e.g. 0 gives seg=8'hC0.
REQ-018 SHALL show a value of 10-15 as dash (segment g only, seg=8'hBF).
REQ-019 SHALL show dash on all six digits while active ovf=1, whatever the data.
REQ-020 SHALL keep exactly one dig_sel bit low at all times after the first post-reset clock.

Reset
REQ-021 SHALL, while Rst_n=0, asynchronously force: seg=8'hFF, dig_sel=6'h3F, frame=0, prescaler=0, index=0, shadow=0, active=0.
REQ-022 SHALL drive dig_sel=6'b111110 from the first rising edge after Rst_n deasserts, with the index starting at 0.
REQ-023 SHALL, if reset is asserted mid-frame, discard any pending shadow value; no stale data is shown after release.

Configuration
REQ-024 SHALL use macro LZB_EN to control leading-zero blanking.
REQ-025 SHALL, when LZB_EN is defined, blank (seg=8'hFF) every digit above the most significant nonzero digit; digit 0 is never blanked, and blanking is suppressed while ovf=1.
REQ-026 SHALL, when LZB_EN is undefined, show all six digits, including leading zeros.

Structure
REQ-027 SHALL take the segment pattern constants (0-9, dash, blank) and the digit count (6) from the shared package.
REQ-028 SHALL instantiate one sub-module, bcd_to_seg: a purely combinational 4-bit BCD to 8-bit active-low segment decoder.
REQ-029 SHALL keep the prescaler, index, shadow/active registers and blanking logic in the top module.

Verification (SCAN_DIV=4)
REQ-030 SHALL test reset release: dig_sel=6'b111110 after the first edge; index advances every 4 clocks; frame pulses every 24 clocks.
REQ-031 SHALL test data=24'h123456 loaded mid-frame: no digit changes before the next frame; after it, digit0 seg=8'h82 (6) and digit5 seg=8'hF9 (1).
REQ-032 SHALL test load in the same cycle as the frame wrap with 24'h000009: that frame shows 9 on digit0; with LZB_EN, digits 1-5 show 8'hFF, and without it they show 8'hC0.
REQ-033 SHALL test ovf=1 with data=24'h999999: all digits show 8'hBF for the whole next frame.
REQ-034 SHALL test data=24'h00000A: digit0 shows 8'hBF (dash).
REQ-035 SHALL test Rst_n pulsed low mid-frame after a pending load: outputs go to reset values at once, and after release all digits show 0 (or blank under LZB_EN), not the pending value.
